// File: rtl/control_setare.sv
// control_setare: button-driven mode sequencer for the time/alarm setting datapath
module control_setare #(
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int CNT_W          = 10
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       btn_mod,
    input  logic       btn_ok,
    input  logic       btn_ore,
    input  logic       btn_min,
    output logic       semnal_setare,
    output logic       semnal_setare_a,
    output logic       semnal_b1,
    output logic       semnal_b2,
    output logic       semnal_stop,
    output logic [1:0] mod_afisaj,
    output logic       timeout_abort
);
    typedef enum logic [2:0] {IDLE, SET_T, CLR, SET_A, COMMIT_T, COMMIT_A} state_t;
    state_t state, nxt;
    logic [3:0] prev;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic e_mod, e_ok, e_ore, e_min, any_e, in_set, tmo, ctl_e;
    logic set_d, set_a_d, stop_d;
    logic [1:0] mod_d;
    assign e_mod  = btn_mod & ~prev[3];
    assign e_ok   = btn_ok  & ~prev[2];
    assign e_ore  = btn_ore & ~prev[1];
    assign e_min  = btn_min & ~prev[0];
    assign any_e  = e_mod | e_ok | e_ore | e_min;
    assign ctl_e  = e_mod | e_ok;
    assign in_set = (state == SET_T) || (state == SET_A);
    // Any edge restarts the inactivity window, so it also suppresses a pending timeout.
    assign tmo    = (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) && !any_e;
    // Counter runs only while staying in a set state with no button activity.
    assign cnt_nxt = (in_set && nxt == state && !any_e) ? cnt + 1'b1 : '0;
    // State, edge history, inactivity counter and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state           <= IDLE;
            prev            <= {btn_mod, btn_ok, btn_ore, btn_min};
            cnt             <= '0;
            semnal_setare   <= 1'b0;
            semnal_setare_a <= 1'b0;
            semnal_b1       <= 1'b0;
            semnal_b2       <= 1'b0;
            semnal_stop     <= 1'b0;
            mod_afisaj      <= 2'd0;
            timeout_abort   <= 1'b0;
        end else begin
            state           <= nxt;
            prev            <= {btn_mod, btn_ok, btn_ore, btn_min};
            cnt             <= cnt_nxt;
            semnal_setare   <= set_d;
            semnal_setare_a <= set_a_d;
            semnal_b1       <= e_ore & in_set & ~ctl_e;
            semnal_b2       <= e_min & in_set & ~ctl_e;
            semnal_stop     <= stop_d;
            mod_afisaj      <= mod_d;
            timeout_abort   <= in_set & tmo & ~ctl_e;
        end
    end
    // Next state: ok beats mod beats timeout; edges in CLR/COMMIT are dropped.
    always_comb begin
        nxt = state;
        case (state)
            IDLE:     nxt = e_mod ? SET_T : IDLE;
            SET_T:    nxt = e_ok ? COMMIT_T : e_mod ? CLR : tmo ? IDLE : SET_T;
            CLR:      nxt = SET_A;
            SET_A:    nxt = e_ok ? COMMIT_A : (e_mod || tmo) ? IDLE : SET_A;
            default:  nxt = IDLE;
        endcase
    end
    // Output decode of the upcoming state, registered alongside it.
    always_comb begin
        set_d   = (nxt == SET_T) || (nxt == COMMIT_T);
        set_a_d = (nxt == SET_A) || (nxt == COMMIT_A);
        stop_d  = (nxt == COMMIT_T) || (nxt == COMMIT_A);
        mod_d   = set_d ? 2'd1 : (set_a_d || nxt == CLR) ? 2'd2 : 2'd0;
    end
endmodule

// File: tb/tb_control_setare.sv
// tb_control_setare: scenario tasks with a per-cycle expected-output scoreboard
module tb_control_setare;
    logic clock = 1'b0, reset = 1'b1;
    logic btn_mod = 1'b0, btn_ok = 1'b0, btn_ore = 1'b0, btn_min = 1'b0;
    logic semnal_setare, semnal_setare_a, semnal_b1, semnal_b2, semnal_stop, timeout_abort;
    logic [1:0] mod_afisaj;
    logic [7:0] outs;
    int passed = 0, total = 0;

    typedef struct packed {logic [4:0] s; logic [7:0] x;} row_t;
    row_t plan[$];
    logic [7:0] sb[$];

    // stimulus bits {reset, mod, ok, ore, min}
    localparam logic [4:0] Z = 5'b00000, R = 5'b10000, M = 5'b01000, K = 5'b00100, H = 5'b00010, N = 5'b00001;
    // output bits {setare, setare_a, b1, b2, stop, mod_afisaj[1:0], abort}
    localparam logic [7:0] I0 = 8'h00, ST = 8'b1000_0010, SA = 8'b0100_0100, CL = 8'b0000_0100;
    localparam logic [7:0] CT = 8'b1000_1010, CA = 8'b0100_1100, B1 = 8'h20, B2 = 8'h10, AB = 8'h01;

    control_setare #(.TIMEOUT_CYCLES(16), .CNT_W(5)) dut (
        .clock(clock), .reset(reset), .btn_mod(btn_mod), .btn_ok(btn_ok),
        .btn_ore(btn_ore), .btn_min(btn_min), .semnal_setare(semnal_setare),
        .semnal_setare_a(semnal_setare_a), .semnal_b1(semnal_b1), .semnal_b2(semnal_b2),
        .semnal_stop(semnal_stop), .mod_afisaj(mod_afisaj), .timeout_abort(timeout_abort)
    );

    assign outs = {semnal_setare, semnal_setare_a, semnal_b1, semnal_b2, semnal_stop, mod_afisaj, timeout_abort};

    always #5 clock = ~clock;

    task automatic add(input logic [4:0] s, input logic [7:0] x, input int n = 1);
        repeat (n) plan.push_back({s, x});
    endtask

    task automatic test_reset;
        row_t r;
        logic [7:0] e;
        add(R | M, I0, 2);
        add(M, I0, 10);
        add(Z, I0);
        add(M, ST);
        add(R, I0);
        while (plan.size() > 0) begin
            r = plan.pop_front();
            {reset, btn_mod, btn_ok, btn_ore, btn_min} = r.s;
            sb.push_back(r.x);
            @(posedge clock); @(negedge clock);
            e = sb.pop_front(); total++;
            if (outs !== e) $display("FAIL reset: outputs %b expected %b", outs, e); else passed++;
        end
    endtask

    task automatic test_set_time;
        row_t r;
        logic [7:0] e;
        add(M, ST);
        add(Z, ST);
        repeat (3) begin
            add(H, ST | B1); add(H, ST); add(Z, ST, 2);
        end
        repeat (2) begin
            add(N, ST | B2); add(N, ST); add(Z, ST, 2);
        end
        add(K, CT);
        add(Z, I0, 2);
        while (plan.size() > 0) begin
            r = plan.pop_front();
            {reset, btn_mod, btn_ok, btn_ore, btn_min} = r.s;
            sb.push_back(r.x);
            @(posedge clock); @(negedge clock);
            e = sb.pop_front(); total++;
            if (outs !== e) $display("FAIL set_time: outputs %b expected %b", outs, e); else passed++;
        end
    endtask

    task automatic test_alarm;
        row_t r;
        logic [7:0] e;
        add(M, ST); add(Z, ST); add(M, CL); add(H, SA); add(Z, SA); add(K, CA); add(Z, I0);
        add(M, ST); add(Z, ST); add(M, CL); add(Z, SA); add(M, I0); add(Z, I0);
        while (plan.size() > 0) begin
            r = plan.pop_front();
            {reset, btn_mod, btn_ok, btn_ore, btn_min} = r.s;
            sb.push_back(r.x);
            @(posedge clock); @(negedge clock);
            e = sb.pop_front(); total++;
            if (outs !== e) $display("FAIL alarm: outputs %b expected %b", outs, e); else passed++;
        end
    endtask

    task automatic test_timeout;
        row_t r;
        logic [7:0] e;
        add(M, ST); add(Z, ST, 15); add(Z, AB); add(Z, I0);
        add(M, ST); add(Z, ST, 8); add(H, ST | B1); add(Z, ST, 15); add(Z, AB); add(Z, I0);
        while (plan.size() > 0) begin
            r = plan.pop_front();
            {reset, btn_mod, btn_ok, btn_ore, btn_min} = r.s;
            sb.push_back(r.x);
            @(posedge clock); @(negedge clock);
            e = sb.pop_front(); total++;
            if (outs !== e) $display("FAIL timeout: outputs %b expected %b", outs, e); else passed++;
        end
    endtask

    task automatic test_simultaneous;
        row_t r;
        logic [7:0] e;
        add(M, ST); add(Z, ST); add(H | N, ST | B1 | B2); add(Z, ST); add(K | H, CT); add(Z, I0);
        add(M, ST); add(Z, ST); add(M | N, CL); add(Z, SA); add(M, I0); add(Z, I0);
        while (plan.size() > 0) begin
            r = plan.pop_front();
            {reset, btn_mod, btn_ok, btn_ore, btn_min} = r.s;
            sb.push_back(r.x);
            @(posedge clock); @(negedge clock);
            e = sb.pop_front(); total++;
            if (outs !== e) $display("FAIL simultaneous: outputs %b expected %b", outs, e); else passed++;
        end
    endtask

    task automatic test_reset_in_commit;
        row_t r;
        logic [7:0] e;
        add(M, ST); add(Z, ST); add(K, CT); add(R, I0); add(Z, I0, 3); add(M, ST); add(Z, ST); add(K, CT); add(Z, I0);
        while (plan.size() > 0) begin
            r = plan.pop_front();
            {reset, btn_mod, btn_ok, btn_ore, btn_min} = r.s;
            sb.push_back(r.x);
            @(posedge clock); @(negedge clock);
            e = sb.pop_front(); total++;
            if (outs !== e) $display("FAIL reset_in_commit: outputs %b expected %b", outs, e); else passed++;
        end
    endtask

    initial begin
        test_reset;
        test_set_time;
        test_alarm;
        test_timeout;
        test_simultaneous;
        test_reset_in_commit;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/control_setare.md
Name: control_setare

Overview:
- Mode-sequencing controller that drives the time/alarm setting datapath (ore/minute set counter) from four debounced front-panel buttons.
- Detects button rising edges and walks an FSM: idle → set time or set alarm → commit.
- Generates the setare/setare_a level enables, the one-cycle increment pulses and the one-cycle stop/commit pulse expected by the setting datapath.
- Aborts a setting session on inactivity and reports the display mode to the display mux.

Parameters:
- TIMEOUT_CYCLES, 1000, idle cycles in a set state before automatic abort (≥2).
- CNT_W, 10, inactivity counter width; must satisfy 2^CNT_W ≥ TIMEOUT_CYCLES.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- btn_mod  in  1  mode button level, already synchronized/debounced.
- btn_ok  in  1  confirm button level.
- btn_ore  in  1  hour-increment button level.
- btn_min  in  1  minute-increment button level.
- semnal_setare  out  1  level: time-setting session active.
- semnal_setare_a  out  1  level: alarm-setting session active.
- semnal_b1  out  1  one-cycle hour-increment pulse.
- semnal_b2  out  1  one-cycle minute-increment pulse.
- semnal_stop  out  1  one-cycle commit pulse.
- mod_afisaj  out  2  display mode: 0 clock, 1 set time, 2 set alarm.
- timeout_abort  out  1  one-cycle pulse when a session is aborted by inactivity.

Behaviour:
- Reset: all outputs 0; state IDLE; counter 0. Edge-detect history registers load the current button levels, so a button held through reset produces no edge.
- Edge: e_x = btn_x & ~prev_x, evaluated every cycle.
- Outputs: all registered. Response appears one cycle after the edge is sampled. Outputs are stable across the falling edge on which the datapath samples.
- States and output decode:
  - IDLE: setare=0, setare_a=0, mod_afisaj=0.
  - SET_T: setare=1, mod_afisaj=1.
  - CLR: both enables 0, mod_afisaj=2.
  - SET_A: setare_a=1, mod_afisaj=2.
  - COMMIT_T: setare=1, stop=1, mod_afisaj=1.
  - COMMIT_A: setare_a=1, stop=1, mod_afisaj=2.
- Transitions:
  - IDLE: e_mod → SET_T. All other edges ignored.
  - SET_T: e_ok → COMMIT_T; else e_mod → CLR; else timeout → IDLE.
  - CLR: unconditional → SET_A. This gives one cycle with both enables low, so the datapath zeroes ore/minute before the alarm session starts.
  - SET_A: e_ok → COMMIT_A; else e_mod → IDLE (cancel, no stop); else timeout → IDLE.
  - COMMIT_T / COMMIT_A: last exactly one cycle, then → IDLE. The enable stays high during stop so the datapath selects the correct load.
- Priority on simultaneous edges: e_ok > e_mod > timeout. Edges arriving in CLR or COMMIT_* are discarded, not queued.
- Increment pulses:
  - semnal_b1 = registered e_ore, semnal_b2 = registered e_min.
  - Passed only when the current state is SET_T or SET_A and no e_ok/e_mod occurs in the same cycle. Otherwise 0.
  - b1 and b2 may pulse in the same cycle.
  - A held button gives exactly one pulse; no auto-repeat.
- Inactivity counter:
  - Cleared to 0 on entry to SET_T/SET_A and on any button edge while in those states; otherwise increments.
  - When it equals TIMEOUT_CYCLES-1 in SET_T/SET_A: go to IDLE, assert timeout_abort for one cycle, no stop pulse.
  - Held at 0 outside set states; never wraps.
- Reset asserted mid-session, including during COMMIT: return to IDLE next edge, stop suppressed, no abort pulse.

Test Plan:
- Reset with btn_mod held high, release reset → no state change; mod_afisaj=0, all pulses 0 for 10 cycles.
- mod edge, then 3 ore edges and 2 min edges spaced 4 cycles, then ok edge → setare=1 from cycle after mod edge; exactly 3 b1 and 2 b2 pulses; one stop pulse with setare=1; setare=0 the following cycle; mod_afisaj 0→1→0.
- mod, mod, ok → SET_T, then one CLR cycle with setare=setare_a=0 and mod_afisaj=2, then setare_a=1; ok gives stop with setare_a=1.
- TIMEOUT_CYCLES=16: mod edge then no input → timeout_abort pulses exactly 16 cycles after SET_T entry; setare drops; no stop. Repeat with an ore edge at cycle 10 → abort delayed to 16 cycles after that edge.
- ok and ore edges in the same cycle during SET_T → stop pulse, no b1 pulse. mod and min edges in the same cycle → CLR, no b2 pulse.
- Reset asserted in the COMMIT_T cycle → stop=0 after the edge, state IDLE, timeout_abort=0.
